// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Request size encodings, FSM state encoding and byte-lane
//               helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;
    localparam logic [1:0] c_size_bad  = 2'b11;

    // Byte-lane enables of an access starting at lane 0
    localparam logic [3:0] c_lanes_byte = 4'b0001;
    localparam logic [3:0] c_lanes_half = 4'b0011;
    localparam logic [3:0] c_lanes_word = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            c_size_byte: return c_lanes_byte;
            c_size_half: return c_lanes_half;
            c_size_word: return c_lanes_word;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            c_size_byte: return 3'd1;
            c_size_half: return 3'd2;
            c_size_word: return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    // An access crosses into the next word when off + nbytes exceeds 4
    function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
        return (({1'b0, off} + size_bytes(size)) > 3'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request, response and word-memory port bundle of the
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [1:0]    req_size;
    logic          req_unsigned;

    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_din;
    logic          mem_we;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we,
        input  mem_rd_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we,
        output mem_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane shifting: store merge into the word
//               being accessed and load extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  wire logic [1:0]  i_off,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    input  wire logic        i_phase,      // 0: first word, 1: following word
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rd_data,
    input  wire logic [31:0] i_lo_word,
    input  wire logic [31:0] i_hi_word,
    output logic      [31:0] o_wr_din,
    output logic      [31:0] o_load_data
);
    logic [63:0] w_wd_shift;
    logic [7:0]  w_mask_shift;
    logic [3:0]  w_lanes;
    logic [31:0] w_wsel;
    logic [63:0] w_pair;
    logic [31:0] w_rd_shift;

    // Store data and lane mask spread across a two-word window
    assign w_wd_shift   = {32'b0, i_wdata} << {i_off, 3'b000};
    assign w_mask_shift = {4'b0, lane_mask(i_size)} << i_off;
    assign w_lanes      = i_phase ? w_mask_shift[7:4] : w_mask_shift[3:0];
    assign w_wsel       = i_phase ? w_wd_shift[63:32] : w_wd_shift[31:0];

    // Replace only the targeted lanes, keep the rest of the read word
    always_comb begin
        o_wr_din = i_rd_data;
        for (int l = 0; l < 4; l++) begin
            if (w_lanes[l]) begin
                o_wr_din[8*l +: 8] = w_wsel[8*l +: 8];
            end
        end
    end

    assign w_pair     = {i_hi_word, i_lo_word};
    assign w_rd_shift = 32'(w_pair >> {i_off, 3'b000});

    // Extend the extracted value to 32 bits
    always_comb begin
        o_load_data = 32'b0;
        case (i_size)
            c_size_byte: o_load_data = i_unsigned ? {24'b0, w_rd_shift[7:0]}
                                                  : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            c_size_half: o_load_data = i_unsigned ? {16'b0, w_rd_shift[15:0]}
                                                  : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            c_size_word: o_load_data = w_rd_shift;
            default:     o_load_data = 32'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte/half/word load-store engine over a word-wide memory with
//               asynchronous read. Misaligned accesses that straddle two words
//               take a second access cycle (read-modify-write for stores).
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  wire logic          clk,
    input  wire logic          rst,
    load_store_unit_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    state_t        r_state;
    logic          r_we;
    logic          r_unsigned;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic [31:0]   r_lo;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [31:0]   r_resp_rdata;

    logic [AW-1:0] w_w0;
    logic [AW-1:0] w_w1;
    logic          w_in_acc;
    logic          w_phase;
    logic [31:0]   w_lo;
    logic [31:0]   w_merge;
    logic [31:0]   w_load;
    logic          w_cross;
    logic          w_unused_addr;

    assign w_w0          = bus.req_addr[AW+1:2];
    assign w_unused_addr = ^bus.req_addr[31:AW+2];
    // Second word wraps around the memory
    assign w_w1          = (r_mem_addr == AW'(DEPTH - 1)) ? '0 : r_mem_addr + AW'(1);
    assign w_in_acc      = (r_state == ACC0) || (r_state == ACC1);
    assign w_phase       = (r_state == ACC1);
    assign w_lo          = w_phase ? r_lo : bus.mem_rd_data;
    assign w_cross       = crosses(r_off, r_size);

    lsu_align u_align (
        .i_off       (r_off),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_phase     (w_phase),
        .i_wdata     (r_wdata),
        .i_rd_data   (bus.mem_rd_data),
        .i_lo_word   (w_lo),
        .i_hi_word   (bus.mem_rd_data),
        .o_wr_din    (w_merge),
        .o_load_data (w_load)
    );

    assign bus.req_ready   = r_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_err    = r_resp_err;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.mem_rd_addr = r_mem_addr;
    assign bus.mem_wr_addr = r_mem_addr;
    assign bus.mem_we      = r_mem_we;
    // Merge data follows the asynchronous read within the same access cycle
    assign bus.mem_wr_din  = (w_in_acc && r_we) ? w_merge : 32'b0;

    // Request sequencing FSM with registered handshake and memory controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_off        <= 2'b0;
            r_size       <= 2'b0;
            r_wdata      <= 32'b0;
            r_lo         <= 32'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_unsigned  <= bus.req_unsigned;
                        r_off       <= bus.req_addr[1:0];
                        r_size      <= bus.req_size;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (bus.req_size == c_size_bad) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'b0;
                        end else begin
                            r_state    <= ACC0;
                            r_mem_addr <= w_w0;
                            r_mem_we   <= bus.req_we;
                        end
                    end
                end
                ACC0: begin
                    r_lo <= bus.mem_rd_data;
                    if (w_cross) begin
                        r_state    <= ACC1;
                        r_mem_addr <= w_w1;
                        r_mem_we   <= r_we;
                    end else begin
                        r_state      <= RESP;
                        r_mem_addr   <= '0;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_we ? 32'b0 : w_load;
                    end
                end
                ACC1: begin
                    r_state      <= RESP;
                    r_mem_addr   <= '0;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_we ? 32'b0 : w_load;
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'b0;
                    r_req_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               four-word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.DEPTH(DEPTH)) bus ();

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [DEPTH];
    logic        pre_we;
    logic [1:0]  pre_addr;
    logic [31:0] pre_data;

    assign bus.mem_rd_data = mem[bus.mem_rd_addr];

    // Memory model: DUT writes plus bench preload port
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_wr_addr] <= bus.mem_wr_din;
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int resp_cnt = 0;
    int lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.mem_we === 1'b1) we_cnt++;
        if (bus.resp_valid === 1'b1) resp_cnt++;
    endtask

    task automatic preload(input logic [1:0] idx, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_addr = idx;
        pre_data = data;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns);
        check("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_valid    = 1'b1;
        tick();
        bus.req_valid    = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat,
                             input logic [31:0] exp_data, input logic exp_err);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, bus.resp_rdata, exp_data);
        check({tag, "_err"}, {31'b0, bus.resp_err}, {31'b0, exp_err});
        tick();
        check({tag, "_valid_drop"}, {31'b0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'b0;
        bus.req_wdata    = 32'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        pre_we           = 1'b0;
        pre_addr         = 2'b0;
        pre_data         = 32'b0;
        for (int i = 0; i < DEPTH; i++) preload(2'(i), 32'h0);

        // Reset state
        check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_rd_addr", {30'b0, bus.mem_rd_addr}, 32'd0);
        check("rst_wr_din", bus.mem_wr_din, 32'd0);
        rst = 1'b0;
        tick();

        // Aligned word store
        we_cnt = 0;
        send(1'b1, 32'h8, 32'hDEADBEEF, 2'b10, 1'b0);
        check("sw_acc0_we", {31'b0, bus.mem_we}, 32'd1);
        check("sw_acc0_wr_addr", {30'b0, bus.mem_wr_addr}, 32'd2);
        check("sw_acc0_din", bus.mem_wr_din, 32'hDEADBEEF);
        wait_resp("sw", 2, 32'h0, 1'b0);
        check("sw_mem2", mem[2], 32'hDEADBEEF);
        check("sw_we_cnt", we_cnt, 32'd1);

        // Loads from mem[1] = 0x80FF7F01
        preload(2'd1, 32'h80FF7F01);
        we_cnt = 0;
        send(1'b0, 32'h6, 32'h0, 2'b00, 1'b0);
        wait_resp("lb_s", 2, 32'hFFFFFFFF, 1'b0);
        send(1'b0, 32'h6, 32'h0, 2'b00, 1'b1);
        wait_resp("lb_u", 2, 32'h000000FF, 1'b0);
        send(1'b0, 32'h4, 32'h0, 2'b01, 1'b0);
        wait_resp("lh_pos", 2, 32'h00007F01, 1'b0);
        send(1'b0, 32'h6, 32'h0, 2'b01, 1'b0);
        wait_resp("lh_neg", 2, 32'hFFFF80FF, 1'b0);
        send(1'b0, 32'h6, 32'h0, 2'b01, 1'b1);
        wait_resp("lhu", 2, 32'h000080FF, 1'b0);
        send(1'b0, 32'h4, 32'h0, 2'b10, 1'b1);
        wait_resp("lw", 2, 32'h80FF7F01, 1'b0);
        check("load_no_we", we_cnt, 32'd0);

        // Crossing word store
        preload(2'd0, 32'hAAAAAAAA);
        preload(2'd1, 32'hAAAAAAAA);
        we_cnt = 0;
        send(1'b1, 32'h3, 32'h11223344, 2'b10, 1'b0);
        wait_resp("sw_x", 3, 32'h0, 1'b0);
        check("sw_x_mem0", mem[0], 32'h44AAAAAA);
        check("sw_x_mem1", mem[1], 32'hAA112233);
        check("sw_x_we_cnt", we_cnt, 32'd2);

        // Byte store into lane 1 preserves neighbours
        send(1'b1, 32'h9, 32'h000000CC, 2'b00, 1'b0);
        wait_resp("sb", 2, 32'h0, 1'b0);
        check("sb_mem2", mem[2], 32'hDEADCCEF);

        // Crossing half load wrapping from word 3 to word 0
        preload(2'd3, 32'h12000000);
        preload(2'd0, 32'h000000AB);
        send(1'b0, 32'hF, 32'h0, 2'b01, 1'b0);
        check("lh_wrap_addr0", {30'b0, bus.mem_rd_addr}, 32'd3);
        tick();
        check("lh_wrap_addr1", {30'b0, bus.mem_rd_addr}, 32'd0);
        wait_resp("lh_wrap", 2, 32'hFFFFAB12, 1'b0);

        // Upper address bits are ignored
        send(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        wait_resp("lw_alias", 2, 32'h000000AB, 1'b0);

        // Illegal size
        we_cnt = 0;
        send(1'b1, 32'h0, 32'hFFFFFFFF, 2'b11, 1'b0);
        check("bad_we", {31'b0, bus.mem_we}, 32'd0);
        wait_resp("bad", 1, 32'h0, 1'b1);
        check("bad_we_cnt", we_cnt, 32'd0);
        check("bad_mem0", mem[0], 32'h000000AB);
        send(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        wait_resp("after_bad", 2, 32'h000000AB, 1'b0);

        // Reset during ACC0 of a crossing store
        preload(2'd0, 32'h55555555);
        preload(2'd1, 32'h55555555);
        send(1'b1, 32'h2, 32'h11223344, 2'b10, 1'b0);
        check("rmid_acc0_we", {31'b0, bus.mem_we}, 32'd1);
        check("rmid_acc0_ready", {31'b0, bus.req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rmid_we_now", {31'b0, bus.mem_we}, 32'd0);
        check("rmid_ready_now", {31'b0, bus.req_ready}, 32'd1);
        check("rmid_din_now", bus.mem_wr_din, 32'd0);
        we_cnt   = 0;
        resp_cnt = 0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("rmid_we_cnt", we_cnt, 32'd0);
        check("rmid_resp_cnt", resp_cnt, 32'd0);
        check("rmid_mem0", mem[0], 32'h55555555);
        check("rmid_mem1", mem[1], 32'h55555555);
        send(1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
        wait_resp("after_rst", 2, 32'h55555555, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
